// File: rtl/fixed_arith_pkg.sv
// Shared constants and saturation-limit helpers for the fixed-point add/sub datapath.
// Limits come back as wide vectors; callers cast them down to their own lane width.
package fixed_arith_pkg;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    localparam int unsigned MAX_WIDTH = 256;

    typedef logic [MAX_WIDTH-1:0] wide_t;

    function automatic wide_t max_pos(input int unsigned width);
        wide_t v;
        v = (wide_t'(1) << (width - 1)) - wide_t'(1);
        return v;
    endfunction

    function automatic wide_t min_neg(input int unsigned width);
        wide_t v;
        v = wide_t'(1) << (width - 1);
        return v;
    endfunction
endpackage

// File: rtl/fixed_addsub_pipe_if.sv
// Operand/result bundle between operand fetch, the add/sub pipe and writeback.
// Input side is valid/accept, output side is ready/accept; the pipe is the slave.
interface fixed_addsub_pipe_if #(
    parameter int WIDTH = 64,
    parameter int LANES = 3
);
    logic [WIDTH*LANES-1:0] iA;
    logic [WIDTH*LANES-1:0] iB;
    logic [LANES-1:0]       iOperation;
    logic                   iSaturate;
    logic                   iInputReady;
    logic                   oInputAccept;
    logic [WIDTH*LANES-1:0] oR;
    logic [LANES-1:0]       oOverflow;
    logic                   OutputReady;
    logic                   iOutputAccept;
    logic                   iClearFlags;
    logic [LANES-1:0]       oOverflowSticky;

    modport master (
        output iA, iB, iOperation, iSaturate, iInputReady, iOutputAccept, iClearFlags,
        input  oInputAccept, oR, oOverflow, OutputReady, oOverflowSticky
    );

    modport slave (
        input  iA, iB, iOperation, iSaturate, iInputReady, iOutputAccept, iClearFlags,
        output oInputAccept, oR, oOverflow, OutputReady, oOverflowSticky
    );
endinterface

// File: rtl/fixed_addsub_lane.sv
// One lane of signed add/subtract with optional saturation; purely combinational.
// Overflow is judged on a one-bit-wider sum so A minus the most-negative value is caught.
module fixed_addsub_lane
    import fixed_arith_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    input  logic             sat,
    output logic [WIDTH-1:0] r,
    output logic             ovf
);
    localparam logic [WIDTH-1:0] SAT_HI = WIDTH'(max_pos(WIDTH));
    localparam logic [WIDTH-1:0] SAT_LO = WIDTH'(min_neg(WIDTH));
    localparam logic [WIDTH:0]   ONE    = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH:0] w_a;
    logic [WIDTH:0] w_b;
    logic [WIDTH:0] w_sum;

    assign w_a   = {a[WIDTH-1], a};
    assign w_b   = (op == OP_SUB) ? (~{b[WIDTH-1], b} + ONE) : {b[WIDTH-1], b};
    assign w_sum = w_a + w_b;
    assign ovf   = w_sum[WIDTH] ^ w_sum[WIDTH-1];
    // The extra sign bit tells which way the true result left the representable range.
    assign r     = (sat && ovf) ? (w_sum[WIDTH] ? SAT_LO : SAT_HI) : w_sum[WIDTH-1:0];
endmodule

// File: rtl/fixed_addsub_pipe.sv
// Two-stage multi-lane fixed-point add/sub: S1 captures operands, S2 holds results (2 cycles).
// A stalled S2 lets S1 fill first, so input accept only drops once both stages hold data.
module fixed_addsub_pipe
    import fixed_arith_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int LANES = 3
) (
    input logic                Clock,
    input logic                Reset,
    fixed_addsub_pipe_if.slave io
);
    logic                   r_v1;
    logic                   r_v2;
    logic [WIDTH*LANES-1:0] r_a1;
    logic [WIDTH*LANES-1:0] r_b1;
    logic [LANES-1:0]       r_op1;
    logic                   r_sat1;
    logic [WIDTH*LANES-1:0] r_res2;
    logic [LANES-1:0]       r_ovf2;
    logic [LANES-1:0]       r_sticky;

    logic                   w_en1;
    logic                   w_en2;
    logic                   w_out_xfer;
    logic [WIDTH*LANES-1:0] w_res;
    logic [LANES-1:0]       w_ovf;

    assign w_en2      = !r_v2 || io.iOutputAccept;
    assign w_en1      = !r_v1 || w_en2;
    assign w_out_xfer = r_v2 && io.iOutputAccept;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fixed_addsub_lane #(.WIDTH(WIDTH)) u_lane (
            .a   (r_a1[i*WIDTH +: WIDTH]),
            .b   (r_b1[i*WIDTH +: WIDTH]),
            .op  (r_op1[i]),
            .sat (r_sat1),
            .r   (w_res[i*WIDTH +: WIDTH]),
            .ovf (w_ovf[i])
        );
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_v1   <= 1'b0;
            r_a1   <= '0;
            r_b1   <= '0;
            r_op1  <= '0;
            r_sat1 <= 1'b0;
        end else if (w_en1) begin
            r_v1   <= io.iInputReady;
            r_a1   <= io.iA;
            r_b1   <= io.iB;
            r_op1  <= io.iOperation;
            r_sat1 <= io.iSaturate;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_v2   <= 1'b0;
            r_res2 <= '0;
            r_ovf2 <= '0;
        end else if (w_en2) begin
            r_v2   <= r_v1;
            r_res2 <= w_res;
            r_ovf2 <= w_ovf;
        end
    end

    // A new overflow leaving the pipe outranks a clear in the same cycle.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_sticky <= '0;
        end else begin
            r_sticky <= (io.iClearFlags ? '0 : r_sticky) | (w_out_xfer ? r_ovf2 : '0);
        end
    end

    assign io.oInputAccept    = w_en1;
    assign io.oR              = r_res2;
    assign io.oOverflow       = r_ovf2;
    assign io.OutputReady     = r_v2;
    assign io.oOverflowSticky = r_sticky;
endmodule

// File: tb/tb_fixed_addsub_pipe.sv
// Bench for fixed_addsub_pipe: directed 8-bit vectors plus a 64-bit run against a reference model.
module tb_fixed_addsub_pipe;
    localparam int L   = 3;
    localparam int W8  = 8;
    localparam int W64 = 64;
    localparam logic signed [65:0] MAXV = {3'b000, {63{1'b1}}};
    localparam logic signed [65:0] MINV = {3'b111, {63{1'b0}}};

    typedef struct {
        logic [191:0] r;
        logic [2:0]   ovf;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic run64 = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_in8  = 0;
    exp_t q8[$];
    exp_t q64[$];
    exp_t m8;
    exp_t m64;

    always #5 clk = ~clk;

    fixed_addsub_pipe_if #(.WIDTH(W8),  .LANES(L)) b8 ();
    fixed_addsub_pipe_if #(.WIDTH(W64), .LANES(L)) b64 ();

    fixed_addsub_pipe #(.WIDTH(W8),  .LANES(L)) dut8  (.Clock(clk), .Reset(rst_n), .io(b8));
    fixed_addsub_pipe #(.WIDTH(W64), .LANES(L)) dut64 (.Clock(clk), .Reset(rst_n), .io(b64));

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    function automatic exp_t model64(input logic [191:0] a, input logic [191:0] b,
                                     input logic [2:0] op, input logic sat);
        exp_t e;
        logic signed [65:0] sa, sb, s;
        e.r   = '0;
        e.ovf = '0;
        for (int i = 0; i < 3; i++) begin
            sa = {{2{a[i*64+63]}}, a[i*64 +: 64]};
            sb = {{2{b[i*64+63]}}, b[i*64 +: 64]};
            s  = op[i] ? (sa - sb) : (sa + sb);
            if (s > MAXV || s < MINV) begin
                e.ovf[i] = 1'b1;
                if (sat) s = (s > MAXV) ? MAXV : MINV;
            end
            e.r[i*64 +: 64] = s[63:0];
        end
        return e;
    endfunction

    function automatic logic [63:0] pick64();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0:       v = 64'h7FFF_FFFF_FFFF_FFFF;
            1:       v = 64'h8000_0000_0000_0000;
            2:       v = 64'h0;
            3:       v = 64'hFFFF_FFFF_FFFF_FFFF;
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    task automatic send8(input logic [23:0] a, input logic [23:0] b, input logic [2:0] op,
                         input logic sat, input logic [23:0] er, input logic [2:0] eovf);
        logic acc;
        int   t;
        exp_t e;
        acc = 1'b0;
        t   = 0;
        b8.iA = a; b8.iB = b; b8.iOperation = op; b8.iSaturate = sat; b8.iInputReady = 1'b1;
        while (!acc && t < 50) begin
            @(negedge clk);
            acc = b8.oInputAccept;
            @(posedge clk);
            t++;
        end
        if (!acc) check("in8_accept_timeout", 192'(acc), 192'(1));
        e.r = '0;
        e.r[23:0] = er;
        e.ovf = eovf;
        if (acc) begin
            q8.push_back(e);
            n_in8++;
        end
        #1 b8.iInputReady = 1'b0;
    endtask

    task automatic send64();
        logic [191:0] a, b;
        logic [2:0]   op;
        logic         sat, acc;
        int           t;
        for (int i = 0; i < 3; i++) begin
            a[i*64 +: 64] = pick64();
            b[i*64 +: 64] = pick64();
        end
        op  = 3'($urandom_range(0, 7));
        sat = 1'($urandom_range(0, 1));
        acc = 1'b0;
        t   = 0;
        b64.iA = a; b64.iB = b; b64.iOperation = op; b64.iSaturate = sat; b64.iInputReady = 1'b1;
        while (!acc && t < 50) begin
            @(negedge clk);
            acc = b64.oInputAccept;
            @(posedge clk);
            t++;
        end
        if (!acc) check("in64_accept_timeout", 192'(acc), 192'(1));
        else q64.push_back(model64(a, b, op, sat));
        #1 b64.iInputReady = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && b8.OutputReady && b8.iOutputAccept) begin
            if (q8.size() == 0) begin
                n_chk++;
                $display("FAIL out8_unexpected: got result %0h, required no output", b8.oR);
            end else begin
                m8 = q8.pop_front();
                check("out8_r", 192'(b8.oR), m8.r);
                check("out8_ovf", 192'(b8.oOverflow), 192'(m8.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b64.OutputReady && b64.iOutputAccept) begin
            if (q64.size() == 0) begin
                n_chk++;
                $display("FAIL out64_unexpected: got result %0h, required no output", b64.oR);
            end else begin
                m64 = q64.pop_front();
                check("out64_r", b64.oR, m64.r);
                check("out64_ovf", 192'(b64.oOverflow), 192'(m64.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        b8.iA = '0; b8.iB = '0; b8.iOperation = '0; b8.iSaturate = 1'b0;
        b8.iInputReady = 1'b0; b8.iOutputAccept = 1'b0; b8.iClearFlags = 1'b0;
        b64.iA = '0; b64.iB = '0; b64.iOperation = '0; b64.iSaturate = 1'b0;
        b64.iInputReady = 1'b0; b64.iOutputAccept = 1'b0; b64.iClearFlags = 1'b0;

        #13;
        check("rst_ready", 192'(b8.OutputReady), 192'(0));
        check("rst_r", 192'(b8.oR), 192'(0));
        check("rst_ovf", 192'(b8.oOverflow), 192'(0));
        check("rst_sticky", 192'(b8.oOverflowSticky), 192'(0));
        check("rst_ready64", 192'(b64.OutputReady), 192'(0));
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        check("accept_after_rst", 192'(b8.oInputAccept), 192'(1));

        // Basic add/sub and the two-edge latency
        b8.iOutputAccept = 1'b1;
        send8(24'hF01010, 24'h200505, 3'b010, 1'b0, 24'h100B15, 3'b000);
        @(negedge clk);
        check("lat_first_edge", 192'(b8.OutputReady), 192'(0));
        @(posedge clk); #1;
        check("lat_second_edge", 192'(b8.OutputReady), 192'(1));

        // Overflow in both modes: 7F+01, 80-01, 00-80; then no-overflow and negative add cases
        send8(24'h00807F, 24'h800101, 3'b110, 1'b1, 24'h7F807F, 3'b111);
        send8(24'h00807F, 24'h800101, 3'b110, 1'b0, 24'h807F80, 3'b111);
        send8(24'h40FF80, 24'h3FFF7F, 3'b010, 1'b1, 24'h7F00FF, 3'b000);
        send8(24'h7F0180, 24'hFF02FF, 3'b110, 1'b1, 24'h7FFF80, 3'b101);
        send8(24'h7F0180, 24'hFF02FF, 3'b110, 1'b0, 24'h80FF7F, 3'b101);
        repeat (4) @(posedge clk); #1;
        check("drain_basic", 192'(q8.size()), 192'(0));
        check("sticky_all", 192'(b8.oOverflowSticky), 192'(3'b111));
        b8.iClearFlags = 1'b1;
        @(posedge clk); #1;
        b8.iClearFlags = 1'b0;
        check("sticky_clear1", 192'(b8.oOverflowSticky), 192'(3'b000));

        // Sticky: lane 1 only, then clear coincident with another lane-1 overflow transfer
        send8(24'h007F00, 24'h000100, 3'b000, 1'b0, 24'h008000, 3'b010);
        repeat (3) @(posedge clk); #1;
        check("sticky_lane1", 192'(b8.oOverflowSticky), 192'(3'b010));
        send8(24'h007F00, 24'h000100, 3'b000, 1'b1, 24'h007F00, 3'b010);
        @(posedge clk); #1;
        b8.iClearFlags = 1'b1;
        @(posedge clk); #1;
        b8.iClearFlags = 1'b0;
        check("sticky_set_wins", 192'(b8.oOverflowSticky), 192'(3'b010));
        @(posedge clk); #1;
        b8.iClearFlags = 1'b1;
        @(posedge clk); #1;
        b8.iClearFlags = 1'b0;
        check("sticky_clear2", 192'(b8.oOverflowSticky), 192'(3'b000));

        // Backpressure: consumer stalls for four edges while five transactions stream in
        b8.iOutputAccept = 1'b0;
        base = n_in8;
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    logic [23:0] va, ve;
                    for (int i = 0; i < 3; i++) begin
                        va[i*8 +: 8] = 8'(16*k + i);
                        ve[i*8 +: 8] = 8'(16*k + i + 3);
                    end
                    send8(va, 24'h030303, 3'b000, 1'b0, ve, 3'b000);
                end
            end
            begin
                repeat (2) @(posedge clk);
                #2;
                check("bp_two_accepts", 192'(n_in8 - base), 192'(2));
                check("bp_accept_low", 192'(b8.oInputAccept), 192'(0));
                check("bp_hold_ready", 192'(b8.OutputReady), 192'(1));
                check("bp_hold_r", 192'(b8.oR), 192'(24'h050403));
                repeat (2) @(posedge clk);
                #1 b8.iOutputAccept = 1'b1;
            end
        join
        repeat (6) @(posedge clk); #1;
        check("bp_drain", 192'(q8.size()), 192'(0));
        check("bp_all_in", 192'(n_in8 - base), 192'(5));

        // Reset with both stages full
        b8.iOutputAccept = 1'b0;
        send8(24'h7F7F7F, 24'h010101, 3'b000, 1'b0, 24'h808080, 3'b111);
        send8(24'h111111, 24'h111111, 3'b000, 1'b0, 24'h222222, 3'b000);
        check("mid_ready", 192'(b8.OutputReady), 192'(1));
        check("mid_full", 192'(b8.oInputAccept), 192'(0));
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready", 192'(b8.OutputReady), 192'(0));
        check("arst_r", 192'(b8.oR), 192'(0));
        check("arst_ovf", 192'(b8.oOverflow), 192'(0));
        q8.delete();
        @(negedge clk);
        rst_n = 1'b1;
        b8.iOutputAccept = 1'b1;
        repeat (5) @(posedge clk); #1;
        check("post_rst_idle", 192'(b8.OutputReady), 192'(0));
        check("post_rst_accept", 192'(b8.oInputAccept), 192'(1));

        // 64-bit back-to-back run with a randomly stalling consumer
        b64.iOutputAccept = 1'b1;
        @(posedge clk); #1;
        run64 = 1'b1;
        fork
            begin
                for (int k = 0; k < 300; k++) send64();
                run64 = 1'b0;
            end
            begin
                while (run64) begin
                    b64.iOutputAccept = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                b64.iOutputAccept = 1'b1;
            end
        join
        repeat (10) @(posedge clk); #1;
        check("drain64", 192'(q64.size()), 192'(0));
        check("drain8_end", 192'(q8.size()), 192'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
